// File: rtl/iob_uart_tx_arb.sv
// Round-robin arbiter sharing one UART transmitter among N_REQ byte-stream requesters.
// A grant covers a whole message (terminated by req_last_i); stalled owners are revoked.
module iob_uart_tx_arb #(
   parameter int unsigned N_REQ   = 4,
   parameter int unsigned DATA_W  = 8,
   parameter int unsigned TIMEOUT = 255
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic [N_REQ-1:0]        req_valid_i,
   input  logic [N_REQ*DATA_W-1:0] req_data_i,
   input  logic [N_REQ-1:0]        req_last_i,
   output logic [N_REQ-1:0]        req_ready_o,
   output logic [N_REQ-1:0]        grant_o,
   output logic                    busy_o,
   input  logic                    tx_ready_i,
   output logic [DATA_W-1:0]       tx_data_o,
   output logic                    data_write_en_o
);

   localparam int unsigned IdxW = $clog2(N_REQ);

   typedef enum logic [1:0] {StIdle, StSend, StIssue, StWaitLow} state_e;

   state_e              r_state;
   state_e              w_next_state;
   logic [N_REQ-1:0]    r_grant;
   logic [IdxW-1:0]     r_gidx;
   logic [IdxW-1:0]     r_last;
   logic [15:0]         r_cnt;
   logic                r_rel;
   logic [DATA_W-1:0]   r_tx_data;
   logic                r_wen;

   logic                w_pick_found;
   logic [IdxW-1:0]     w_pick_idx;
   logic [IdxW-1:0]     w_cand;
   logic [N_REQ-1:0]    w_pick_onehot;
   logic                w_gvalid;
   logic                w_glast;
   logic [DATA_W-1:0]   w_gdata;
   logic                w_accept;
   logic [15:0]         w_cnt_inc;
   logic                w_timeout;

   // Search upward from the previous owner so every waiting requester gets a turn.
   always_comb begin
      w_pick_found = 1'b0;
      w_pick_idx   = '0;
      w_cand       = '0;
      for (int unsigned k = 1; k <= N_REQ; k++) begin
         w_cand = IdxW'((32'(r_last) + k) % N_REQ);
         if (!w_pick_found && req_valid_i[w_cand]) begin
            w_pick_found = 1'b1;
            w_pick_idx   = w_cand;
         end
      end
   end

   assign w_pick_onehot = N_REQ'(1) << w_pick_idx;
   assign w_gvalid      = req_valid_i[r_gidx];
   assign w_glast       = req_last_i[r_gidx];
   assign w_gdata       = req_data_i[32'(r_gidx)*DATA_W +: DATA_W];
   assign w_accept      = tx_ready_i && w_gvalid;
   assign w_cnt_inc     = r_cnt + 16'd1;
   assign w_timeout     = !w_gvalid && (w_cnt_inc == 16'(TIMEOUT));

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state <= StIdle;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         StIdle: begin
            if (w_pick_found) w_next_state = StSend;
         end
         StSend: begin
            if (w_accept) begin
               w_next_state = StIssue;
            end else if (w_timeout) begin
               w_next_state = StIdle;
            end
         end
         StIssue: begin
            w_next_state = StWaitLow;
         end
         StWaitLow: begin
            // tx_ready_i low proves the UART latched the byte; earlier it may be stale.
            if (!tx_ready_i) w_next_state = r_rel ? StIdle : StSend;
         end
         default: begin
            w_next_state = StIdle;
         end
      endcase
   end

   always_comb begin
      req_ready_o     = (r_state == StSend && w_accept) ? r_grant : '0;
      grant_o         = r_grant;
      busy_o          = (r_state != StIdle);
      tx_data_o       = r_tx_data;
      data_write_en_o = r_wen;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_grant   <= '0;
         r_gidx    <= '0;
         r_last    <= IdxW'(N_REQ - 1);
         r_cnt     <= '0;
         r_rel     <= 1'b0;
         r_tx_data <= '0;
         r_wen     <= 1'b0;
      end else begin
         r_wen <= 1'b0;
         case (r_state)
            StIdle: begin
               if (w_pick_found) begin
                  r_grant <= w_pick_onehot;
                  r_gidx  <= w_pick_idx;
                  r_last  <= w_pick_idx;
                  r_cnt   <= '0;
               end
            end
            StSend: begin
               if (w_accept) begin
                  r_tx_data <= w_gdata;
                  r_rel     <= w_glast;
                  r_wen     <= 1'b1;
                  r_cnt     <= '0;
               end else if (w_timeout) begin
                  r_grant <= '0;
                  r_cnt   <= '0;
               end else if (!w_gvalid) begin
                  r_cnt <= w_cnt_inc;
               end else begin
                  r_cnt <= '0;
               end
            end
            StWaitLow: begin
               if (!tx_ready_i) begin
                  if (r_rel) begin
                     r_grant <= '0;
                  end else begin
                     r_cnt <= '0;
                  end
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule
